// File: rtl/opl_op_cfg_ring_pkg.sv
// Shared definitions for the OPL per-operator configuration ring.
package opl_op_cfg_ring_pkg;

  localparam int unsigned LEN_DEF = 18;
  localparam int unsigned W_DEF   = 32;

  localparam int unsigned MUL_LANE_HI   = 31;
  localparam int unsigned MUL_LANE_LO   = 24;
  localparam int unsigned KSLTL_LANE_HI = 23;
  localparam int unsigned KSLTL_LANE_LO = 16;
  localparam int unsigned ARDR_LANE_HI  = 15;
  localparam int unsigned ARDR_LANE_LO  = 8;
  localparam int unsigned SLRR_LANE_HI  = 7;
  localparam int unsigned SLRR_LANE_LO  = 0;

  // Field view of one slot's configuration word.
  typedef struct packed {
    logic       amen;
    logic       viben;
    logic       en_sus;
    logic       ks;
    logic [3:0] mul;
    logic [1:0] ksl;
    logic [5:0] tl;
    logic [3:0] ar;
    logic [3:0] dr;
    logic [3:0] sl;
    logic [3:0] rr;
  } op_cfg_t;

endpackage

// File: rtl/opl_sh_ring.sv
// Generic clock-enabled shift register; output is the last stage.
module opl_sh_ring #(
  parameter int unsigned width  = 1,
  parameter int unsigned stages = 2,
  parameter logic [width-1:0] rstval = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop
);

  logic [width-1:0] bank [stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(stages); i++) bank[i] <= rstval;
    end else if (cen) begin
      bank[0] <= din;
      for (int i = 1; i < int'(stages); i++) bank[i] <= bank[i-1];
    end
  end

  assign drop = bank[stages-1];

endmodule

// File: rtl/opl_op_cfg_ring.sv
// Per-operator configuration store: circulating ring with lane-wise CPU writes
// into the slot currently at the ring output.
module opl_op_cfg_ring
  import opl_op_cfg_ring_pkg::*;
#(
  parameter int unsigned LEN = LEN_DEF,
  parameter int unsigned W   = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic [7:0]   din,
  input  logic         up_mult,
  input  logic         up_ksl_tl,
  input  logic         up_ar_dr,
  input  logic         up_sl_rr,
  input  logic         update_op_I,
  input  logic         update_op_II,
  input  logic         update_op_IV,
  output logic [W-1:0] shift_out
);

  logic [W-1:0] next_in;

  // Each lane is qualified by the pipeline stage that consumes it downstream.
  always_comb begin
    next_in = shift_out;
    if (up_mult && update_op_II)   next_in[MUL_LANE_HI:MUL_LANE_LO]     = din;
    if (up_ksl_tl && update_op_IV) next_in[KSLTL_LANE_HI:KSLTL_LANE_LO] = din;
    if (up_ar_dr && update_op_I)   next_in[ARDR_LANE_HI:ARDR_LANE_LO]   = din;
    if (up_sl_rr && update_op_I)   next_in[SLRR_LANE_HI:SLRR_LANE_LO]   = din;
  end

  opl_sh_ring #(
    .width  (W),
    .stages (LEN),
    .rstval ('0)
  ) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .din   (next_in),
    .drop  (shift_out)
  );

endmodule

// File: tb/tb_opl_op_cfg_ring.sv
// Bench for opl_op_cfg_ring: directed steps plus random traffic against a slot-array model.
module tb_opl_op_cfg_ring;

  localparam int unsigned LEN = 18;
  localparam int unsigned W   = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cen;
  logic [7:0]   din;
  logic         up_mult, up_ksl_tl, up_ar_dr, up_sl_rr;
  logic         update_op_I, update_op_II, update_op_IV;
  logic [W-1:0] shift_out;

  always #5 clk = ~clk;

  opl_op_cfg_ring #(.LEN(LEN), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .din          (din),
    .up_mult      (up_mult),
    .up_ksl_tl    (up_ksl_tl),
    .up_ar_dr     (up_ar_dr),
    .up_sl_rr     (up_sl_rr),
    .update_op_I  (update_op_I),
    .update_op_II (update_op_II),
    .update_op_IV (update_op_IV),
    .shift_out    (shift_out)
  );

  // Model: one word per slot; ptr names the slot currently presented at the output.
  logic [W-1:0] mdl [LEN];
  int unsigned  ptr;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (shift_out === exp)
    else begin
      failures++;
      $error("FAIL %s: shift_out=%08h expected=%08h", tag, shift_out, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < int'(LEN); i++) mdl[i] = '0;
    ptr = 0;
  endtask

  // One clock: drive on negedge, update model at posedge, compare just after.
  task automatic tick(input bit c, input logic [7:0] d, input bit m, input bit k,
                      input bit a, input bit s, input bit i1, input bit i2, input bit i4,
                      input string tag);
    logic [W-1:0] v;
    @(negedge clk);
    cen = c; din = d;
    up_mult = m; up_ksl_tl = k; up_ar_dr = a; up_sl_rr = s;
    update_op_I = i1; update_op_II = i2; update_op_IV = i4;
    @(posedge clk);
    #1;
    if (c) begin
      v = mdl[ptr];
      if (m && i2) v[31:24] = d;
      if (k && i4) v[23:16] = d;
      if (a && i1) v[15:8]  = d;
      if (s && i1) v[7:0]   = d;
      mdl[ptr] = v;
      ptr = (ptr + 1) % LEN;
    end
    chk(tag, mdl[ptr]);
  endtask

  task automatic idle(input string tag);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic goto_slot(input int unsigned slot);
    for (int n = 0; n < int'(LEN) && ptr != slot; n++) idle("goto");
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    cen = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mdl_clear();
    chk(tag, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; din = 8'h00;
    up_mult = 0; up_ksl_tl = 0; up_ar_dr = 0; up_sl_rr = 0;
    update_op_I = 0; update_op_II = 0; update_op_IV = 0;
    mdl_clear();
    #1 chk("reset_state", 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2 * int'(LEN); i++) begin
      idle("post_reset_idle");
      chk("post_reset_zero", 32'h0);
    end

    // Recirculation: 0xA5 into the AR/DR lane of slot 0, seen every LEN cens.
    goto_slot(0);
    tick(1, 8'hA5, 0, 0, 1, 0, 1, 0, 0, "recirc_wr");
    for (int lap = 0; lap < 3; lap++) begin
      for (int j = 0; j < int'(LEN) - 1; j++) idle("recirc_idle");
      chk("recirc_lap", 32'h0000A500);
      if (lap < 2) idle("recirc_next");
    end

    // Stage alignment: mult on II, ksl/tl on IV in slot 2; an I-only write to slot 3 changes nothing.
    goto_slot(2);
    tick(1, 8'h3C, 1, 1, 0, 0, 0, 1, 1, "align_wr");
    tick(1, 8'h77, 1, 1, 0, 0, 1, 0, 0, "align_I_only");
    goto_slot(2);
    chk("align_slot2", 32'h3C3C0000);
    idle("align_to3");
    chk("align_slot3", 32'h0);

    // cen gating: strobes with cen low are ignored; period counts cen pulses only.
    goto_slot(12);
    tick(0, 8'hFF, 1, 1, 1, 1, 1, 1, 1, "cen0_wr");
    chk("cen0_nochange", 32'h0);
    tick(1, 8'h5A, 0, 0, 1, 0, 1, 0, 0, "cen_wr");
    for (int j = 0; j < int'(LEN) - 1; j++) begin
      for (int h = 0; h < 10; h++) tick(0, 8'hEE, 1, 1, 1, 1, 1, 1, 1, "cen_hold");
      idle("cen_pulse");
    end
    chk("cen_period", 32'h00005A00);

    // Independent lanes across laps in slot 5; slot 6 untouched.
    goto_slot(5);
    tick(1, 8'h12, 0, 0, 0, 1, 1, 0, 0, "lane_slrr");
    goto_slot(5);
    tick(1, 8'h34, 0, 0, 1, 0, 1, 0, 0, "lane_ardr");
    goto_slot(5);
    chk("lane_slot5", 32'h00003412);
    idle("lane_to6");
    chk("lane_slot6", 32'h0);

    // Overwrite of the mult lane on consecutive laps.
    goto_slot(9);
    tick(1, 8'hFF, 1, 0, 0, 0, 0, 1, 0, "ovr_ff");
    goto_slot(9);
    chk("ovr_first", 32'hFF000000);
    tick(1, 8'h0F, 1, 0, 0, 0, 0, 1, 0, "ovr_0f");
    goto_slot(9);
    chk("ovr_final", 32'h0F000000);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(3) != 0), 8'($urandom),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(1) == 0), ($urandom_range(1) == 0),
           ($urandom_range(1) == 0), "random");
    end

    // Mid-stream reset discards everything.
    do_reset("midstream_reset");
    for (int i = 0; i < 2 * int'(LEN); i++) begin
      idle("post_reset2_idle");
      chk("post_reset2_zero", 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/opl_op_cfg_ring.md
Name: opl_op_cfg_ring

Overview:
- Per-operator configuration store for the OPL FM core, wrapped as one block.
- Holds four register bytes per operator slot in a circulating shift ring of LEN stages, one stage per slot.
- The ring advances once per cen.
- The slot currently at the ring output is the active pipeline slot. Its byte lanes can be overwritten from the CPU data bus when the matching update strobe and stage-qualified slot match are both high.

Parameters:
- LEN, 18, number of operator slots (ring depth in stages).
- W, 32, bits stored per slot (four 8-bit lanes).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable; ring shifts only when high.
- din  in  8  CPU write data byte.
- up_mult  in  1  write strobe, register 0x20 family (AM/VIB/EG-type/KSR/MULT).
- up_ksl_tl  in  1  write strobe, 0x40 family (KSL/TL).
- up_ar_dr  in  1  write strobe, 0x60 family (AR/DR).
- up_sl_rr  in  1  write strobe, 0x80 family (SL/RR).
- update_op_I  in  1  current output slot is the addressed operator, stage I.
- update_op_II  in  1  same match, delayed one slot (stage II).
- update_op_IV  in  1  same match, delayed three slots (stage IV).
- shift_out  out  W  configuration of the current slot.

shift_out field map:
- [31]=amen, [30]=viben, [29]=en_sus, [28]=ks, [27:24]=mul
- [23:22]=ksl, [21:16]=tl
- [15:12]=ar, [11:8]=dr
- [7:4]=sl, [3:0]=rr

Behaviour:
- Ring: internal shift register of LEN stages, each W bits wide.
  - On each clk edge with cen=1: stage0<=next_in, stage k<=stage k-1.
  - shift_out = stage LEN-1 (registered, no combinational path from din).
  - cen=0 holds all stages; write strobes have no effect while cen=0.
- next_in, built lane by lane:
  - [31:24] = (up_mult & update_op_II) ? din : shift_out[31:24]
  - [23:16] = (up_ksl_tl & update_op_IV) ? din : shift_out[23:16]
  - [15:8] = (up_ar_dr & update_op_I) ? din : shift_out[15:8]
  - [7:0] = (up_sl_rr & update_op_I) ? din : shift_out[7:0]
- Non-updated lanes recirculate unchanged. A value therefore reappears at shift_out exactly LEN cen cycles after it left.
- Lanes are independent: several strobes in the same cycle update each qualified lane with the same din.
- A write lands in the stage present on that cen. It becomes visible at shift_out LEN cen cycles later.
- Lane-to-stage qualification: the upper lane is keyed to stage II and the 0x40 lane to stage IV. This makes each lane line up with the slot that downstream pipeline stages consume.
- Reset: async on rst_n low; all stages clear to 0, so shift_out=0.
  - Reset mid-operation discards all stored configuration.
  - Release is synchronous to the next clk edge; the first shift occurs on the first cen after release.
- No handshake: strobes are single-cycle qualified; a strobe held over k cen cycles rewrites the lane k times, each time in whichever slot is current.

Decomposition:
- Shared package: lane bit positions (MUL_LANE 31:24, KSLTL_LANE 23:16, ARDR_LANE 15:8, SLRR_LANE 7:0), LEN default 18, W default 32.
- One sub-module: opl_sh_ring. Generic cen-gated shift register with parameters width, stages and rstval (default 0), async active-low reset, output = last stage. It is instantiated once with width=W, stages=LEN.

Test Plan:
- Reset: drive rst_n=0 mid-stream after nonzero writes → shift_out=0 immediately; after release with no writes, shift_out stays 0 for 2*LEN cen cycles.
- Recirculation: write din=0xA5 with up_ar_dr & update_op_I at cycle t → shift_out[15:8]=0xA5 at t+18, t+36, t+54; other lanes stay 0; shift_out differs at non-matching cycles.
- Stage alignment: same cycle, din=0x3C with up_mult & update_op_II and up_ksl_tl & update_op_IV → both lanes 0x3C in that slot, arriving 18 cen later; with update_op_I only (II/IV low), no change.
- cen gating: write with cen=0 → no stage changes; hold cen=0 for 10 clks between shifts → the recirculation period is still 18 cen pulses.
- Independent lanes: write 0x12 to sl_rr in slot 5, then 0x34 to ar_dr in slot 5 one lap later → slot 5 reads 0x00003412; slot 6 remains 0.
- Overwrite: write 0xFF then 0x0F to the mult lane of the same slot on consecutive laps → the final lane value is 0x0F.
